// File: rtl/ilda_pkg.sv
// rtl/ilda_pkg.sv - shared flag positions, state encoding and limits for ILDA playback
package ilda_pkg;

  localparam int LAST_POINT_BIT = 31;
  localparam int LAST_FRAME_BIT = 30;
  localparam int BLANK_BIT      = 29;
  localparam int MIN_PERIOD     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_READ,
    ST_LATCH
  } seq_state_t;

endpackage

// File: rtl/point_rate_divider.sv
// rtl/point_rate_divider.sv - point-period divider with minimum-period clamp
module point_rate_divider
  import ilda_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_eff;

  // Periods shorter than the READ/LATCH pipeline cannot be honoured, so clamp them.
  always_comb begin
    period_eff = period;
    if (period < DIV_W'(MIN_PERIOD)) period_eff = DIV_W'(MIN_PERIOD);
  end

  assign tick = !clear && (cnt == period_q - 1'b1);

  // Count 0..P-1; the period is only re-sampled on reload so a mid-count change never shortens a point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      period_q <= DIV_W'(MIN_PERIOD);
    end else if (clear || tick) begin
      cnt      <= '0;
      period_q <= period_eff;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ilda_frame_sequencer.sv
// rtl/ilda_frame_sequencer.sv - paced ILDA point playback with frame repeat and image wrap
module ilda_frame_sequencer
  import ilda_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16,
  parameter int RPT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  point_period,
  input  logic [RPT_W-1:0]  frame_repeat,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] point_data,
  output logic              point_valid,
  output logic              blank,
  output logic              frame_start,
  output logic              busy
);

  seq_state_t        state;
  seq_state_t        state_next;
  logic [ADDR_W-1:0] frame_base;
  logic [RPT_W-1:0]  rpt_cnt;
  logic              first;
  logic              tick;
  logic              div_clear;

  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] next_base;
  logic [RPT_W-1:0]  next_rpt;
  logic              next_first;
  logic              last_point;
  logic              last_frame;
  logic              addr_all_ones;

  assign div_clear     = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign last_point    = rom_dout[LAST_POINT_BIT];
  assign last_frame    = rom_dout[LAST_FRAME_BIT];
  assign addr_all_ones = &rom_address;

  point_rate_divider #(
    .DIV_W (DIV_W)
  ) u_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (div_clear),
    .period (point_period),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state: a point already in READ/LATCH always completes before honouring a disable.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (enable) state_next = ST_WAIT_TICK;
      ST_WAIT_TICK: begin
        if (!enable)   state_next = ST_IDLE;
        else if (tick) state_next = ST_READ;
      end
      ST_READ:      state_next = ST_LATCH;
      ST_LATCH:     state_next = enable ? ST_WAIT_TICK : ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Address sequencing decided from the flags of the point being latched.
  always_comb begin
    next_addr  = rom_address + 1'b1;
    next_base  = frame_base;
    next_rpt   = rpt_cnt;
    next_first = 1'b0;
    if (!last_point) begin
      if (addr_all_ones) begin
        next_addr  = start_addr;
        next_base  = start_addr;
        next_rpt   = '0;
        next_first = 1'b1;
      end
    end else if (rpt_cnt < frame_repeat) begin
      next_rpt   = rpt_cnt + 1'b1;
      next_addr  = frame_base;
      next_first = 1'b1;
    end else begin
      next_rpt   = '0;
      next_first = 1'b1;
      if (last_frame || addr_all_ones) next_addr = start_addr;
      next_base  = next_addr;
    end
  end

  // Output and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_address <= '0;
      point_data  <= '0;
      point_valid <= 1'b0;
      frame_start <= 1'b0;
      blank       <= 1'b1;
      frame_base  <= '0;
      rpt_cnt     <= '0;
      first       <= 1'b0;
    end else begin
      point_valid <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          rom_address <= start_addr;
          blank       <= 1'b1;
          if (enable) begin
            frame_base <= start_addr;
            rpt_cnt    <= '0;
            first      <= 1'b1;
          end
        end
        ST_LATCH: begin
          point_data  <= rom_dout;
          point_valid <= 1'b1;
          blank       <= rom_dout[BLANK_BIT];
          frame_start <= first;
          first       <= next_first;
          rom_address <= next_addr;
          frame_base  <= next_base;
          rpt_cnt     <= next_rpt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ilda_frame_sequencer.sv
// tb/tb_ilda_frame_sequencer.sv - randomized self-checking bench for ilda_frame_sequencer
module tb_ilda_frame_sequencer;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int DIV_W  = 16;
  localparam int RPT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [DIV_W-1:0]  point_period = 16'd10;
  logic [RPT_W-1:0]  frame_repeat = '0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] point_data;
  logic              point_valid;
  logic              blank;
  logic              frame_start;
  logic              busy;

  logic [31:0] rom [0:2047];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_ref = 0;
  int m_addr, m_base, m_rpt;
  bit m_first;

  ilda_frame_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W),
    .RPT_W  (RPT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .point_period (point_period),
    .frame_repeat (frame_repeat),
    .start_addr   (start_addr),
    .rom_address  (rom_address),
    .rom_dout     (rom_dout),
    .point_data   (point_data),
    .point_valid  (point_valid),
    .blank        (blank),
    .frame_start  (frame_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_dout <= rom[rom_address];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame A at 0..3, frame B at 4..5 ending the image, plain points at 2040..2047.
  task automatic fill_rom();
    logic [31:0] w;
    for (int a = 0; a < 2048; a++) rom[a] = '0;
    for (int a = 0; a < 6; a++) begin
      w = $urandom;
      w[31:30] = 2'b00;
      w[0] = 1'b1;
      rom[a] = w;
    end
    rom[3][31] = 1'b1;
    rom[5][31] = 1'b1;
    rom[5][30] = 1'b1;
    for (int a = 2040; a < 2048; a++) begin
      w = $urandom;
      w[31:29] = 3'b000;
      rom[a] = w;
    end
  endtask

  function automatic void model_start(input int s);
    m_addr  = s;
    m_base  = s;
    m_rpt   = 0;
    m_first = 1'b1;
  endfunction

  // Which point plays after m_addr, from the flag rules of the image format.
  function automatic void model_advance(input int rpt, input int start);
    logic [31:0] w;
    w = rom[m_addr];
    m_first = 1'b0;
    if (!w[31]) begin
      if (m_addr == 2047) begin
        m_addr = start; m_base = start; m_rpt = 0; m_first = 1'b1;
      end else begin
        m_addr = m_addr + 1;
      end
    end else if (m_rpt < rpt) begin
      m_rpt = m_rpt + 1;
      m_addr = m_base;
      m_first = 1'b1;
    end else begin
      m_rpt = 0;
      m_first = 1'b1;
      m_addr = (w[30] || m_addr == 2047) ? start : m_addr + 1;
      m_base = m_addr;
    end
  endfunction

  task automatic take_point(input int p_eff, input bit first_pt, input int rpt, input int start);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (point_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("valid_timeout", 64'(got), 64'd1);
    if (got) begin
      if (first_pt) begin
        check("latency", 64'(cyc - t_ref), 64'(p_eff + 3));
        check("busy_run", 64'(busy), 64'd1);
      end else begin
        check("spacing", 64'(cyc - t_ref), 64'(p_eff));
      end
      t_ref = cyc;
      check("point_data", 64'(point_data), 64'(rom[m_addr]));
      check("frame_start", 64'(frame_start), 64'(m_first));
      check("blank", 64'(blank), 64'(rom[m_addr][29]));
      model_advance(rpt, start);
    end
  endtask

  task automatic start_run(input int start, input int rpt, input int per);
    start_addr   = ADDR_W'(start);
    frame_repeat = RPT_W'(rpt);
    point_period = DIV_W'(per);
    model_start(start);
    @(negedge clk);
    enable = 1'b1;
    t_ref = cyc;
  endtask

  task automatic stop_run();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check("idle_blank", 64'(blank), 64'd1);
  endtask

  task automatic run_segment(input int start, input int rpt, input int per, input int npts);
    int p_eff;
    p_eff = (per < 3) ? 3 : per;
    start_run(start, rpt, per);
    for (int i = 0; i < npts; i++) take_point(p_eff, i == 0, rpt, start);
    stop_run();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt;
    fill_rom();
    repeat (3) @(negedge clk);
    check("rst_rom_address", 64'(rom_address), 64'd0);
    check("rst_point_data", 64'(point_data), 64'd0);
    check("rst_point_valid", 64'(point_valid), 64'd0);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    check("rst_blank", 64'(blank), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_segment(0, 0, 10, 8);
    run_segment(0, 2, 10, 20);
    run_segment(0, 0, 1, 8);
    run_segment(2040, 0, 5, 10);

    // Disable while a point is in READ: exactly that point still comes out.
    start_run(0, 0, 10);
    take_point(10, 1'b1, 0, 0);
    take_point(10, 1'b0, 0, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (point_valid) begin
        cnt++;
        if (cnt == 1) check("drop_point_data", 64'(point_data), 64'(rom[m_addr]));
      end
    end
    check("drop_extra_points", 64'(cnt), 64'd1);
    check("drop_busy", 64'(busy), 64'd0);
    check("drop_blank", 64'(blank), 64'd1);
    check("drop_rom_address", 64'(rom_address), 64'd0);
    run_segment(4, 0, 10, 6);

    // Asynchronous reset during LATCH.
    rom[1][29] = 1'b0;
    rom[2][29] = 1'b0;
    start_run(0, 0, 10);
    take_point(10, 1'b1, 0, 0);
    take_point(10, 1'b0, 0, 0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_point_valid", 64'(point_valid), 64'd0);
    check("arst_blank", 64'(blank), 64'd1);
    check("arst_rom_address", 64'(rom_address), 64'd0);
    check("arst_point_data", 64'(point_data), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 6; it++) begin
      fill_rom();
      run_segment(($urandom_range(0, 1) == 0) ? 0 : 4, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 12)), int'($urandom_range(8, 20)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
